key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Multi-key push-button debouncer with press/release pulses on a shared sample tick.
// Define KEY_LONG_PRESS_EN to build the per-key long-press detector; otherwise key_long is tied to 0.
module key_debounce #(
  parameter int KEY_W      = 4,
  parameter int TICK_DIV   = 25_000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000
) (
  input  logic             ext_clk_25m,
  input  logic             ext_rst_n,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] key_down,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  // A level is accepted on the tick that would bring the count to DEB_TICKS.
  localparam logic [DEB_W-1:0]  DEB_NEAR  = DEB_W'(DEB_TICKS - 1);

  if (TICK_DIV < 1 || DEB_TICKS < 2 || LONG_TICKS < 1) begin : g_param_check
    $error("key_debounce: TICK_DIV>=1, DEB_TICKS>=2, LONG_TICKS>=1 required");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } key_state_t;

  logic [KEY_W-1:0]  key_n_p0;
  logic [KEY_W-1:0]  key_n_p1;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  key_state_t        state   [KEY_W];
  logic [DEB_W-1:0]  deb_cnt [KEY_W];

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_TICKS + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TICKS);
  localparam logic [LONG_W-1:0] LONG_NEAR = LONG_W'(LONG_TICKS - 1);

  logic [LONG_W-1:0] long_cnt [KEY_W];
`else
  assign key_long = '0;
`endif

  // p0 -> p1: two-flop synchroniser; idle level (released) is 1
  always_ff @(posedge ext_clk_25m) begin
    if (!ext_rst_n) begin
      key_n_p0 <= '1;
      key_n_p1 <= '1;
    end else begin
      key_n_p0 <= key_n;
      key_n_p1 <= key_n_p0;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge ext_clk_25m) begin
    if (!ext_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // p1 -> outputs: per-key debounce FSMs, advanced only on tick
  always_ff @(posedge ext_clk_25m) begin
    if (!ext_rst_n) begin
      for (int k = 0; k < KEY_W; k++) begin
        state[k]   <= IDLE;
        deb_cnt[k] <= '0;
`ifdef KEY_LONG_PRESS_EN
        long_cnt[k] <= '0;
`endif
      end
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= '0;
`endif
    end else begin
      key_press   <= '0;
      key_release <= '0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= '0;
`endif
      if (tick) begin
        for (int k = 0; k < KEY_W; k++) begin
          case (state[k])
            IDLE: begin
              if (!key_n_p1[k]) begin
                state[k]   <= PRESS_DB;
                deb_cnt[k] <= DEB_W'(1);
              end
            end
            PRESS_DB: begin
              if (key_n_p1[k]) begin
                state[k]   <= IDLE;
                deb_cnt[k] <= '0;
              end else if (deb_cnt[k] == DEB_NEAR) begin
                state[k]     <= PRESSED;
                deb_cnt[k]   <= '0;
                key_down[k]  <= 1'b1;
                key_press[k] <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
                long_cnt[k]  <= '0;
`endif
              end else begin
                deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
              end
            end
            PRESSED: begin
              if (key_n_p1[k]) begin
                state[k]   <= RELEASE_DB;
                deb_cnt[k] <= DEB_W'(1);
              end
            end
            RELEASE_DB: begin
              if (!key_n_p1[k]) begin
                state[k]   <= PRESSED;
                deb_cnt[k] <= '0;
              end else if (deb_cnt[k] == DEB_NEAR) begin
                state[k]       <= IDLE;
                deb_cnt[k]     <= '0;
                key_down[k]    <= 1'b0;
                key_release[k] <= 1'b1;
              end else begin
                deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
              end
            end
            default: begin
              state[k]   <= IDLE;
              deb_cnt[k] <= '0;
            end
          endcase

`ifdef KEY_LONG_PRESS_EN
          // Hold time keeps accruing through a release bounce; it restarts only on a new press.
          if ((state[k] == PRESSED || state[k] == RELEASE_DB) && long_cnt[k] != LONG_LAST) begin
            long_cnt[k] <= long_cnt[k] + LONG_W'(1);
            if (long_cnt[k] == LONG_NEAR) begin
              key_long[k] <= 1'b1;
            end
          end
`endif
        end
      end
    end
  end

endmodule
